mux_serializer: RTL and testbench
=================================

Name: mux_serializer

Overview:
Parallel-in, serial-out stage that sits directly upstream of the parameterized mux. It captures a 2**p_sel_width-bit word through a valid/ready handshake. A select counter then steps through every bit index, and an internal mux instance drives one data bit per accepted transfer. It drives both the select index and the selected bit, so downstream logic and benches can check o_w_bit against the captured word[o_w_sel].

Parameters:
p_sel_width, 2, select width; the word width is W = 2**p_sel_width.
p_msb_first, 0, 0 = emit index 0 first and count up; 1 = emit index W-1 first and count down.

Ports:
i_w_clk  input  1  clock; all state updates on the rising edge
i_w_reset  input  1  asynchronous, active-high reset
i_w_data  input  W  parallel word to serialize
i_w_valid  input  1  i_w_data is valid this cycle
o_w_ready  output  1  block accepts a word this cycle
o_w_bit  output  1  current serial bit = captured_word[o_w_sel]
o_w_sel  output  p_sel_width  index of the current bit
o_w_bit_valid  output  1  o_w_bit/o_w_sel are valid
i_w_bit_ready  input  1  consumer accepts the current bit
o_w_last  output  1  current bit is the final bit of the word
o_w_busy  output  1  a word is being serialized

Behaviour:
- Reset (asynchronous, active-high) takes effect immediately, independent of the clock.
  - State goes to IDLE; the captured word register clears to 0.
  - o_w_sel resets to 0 (p_msb_first=0) or W-1 (p_msb_first=1).
  - o_w_bit_valid=0, o_w_last=0, o_w_busy=0, o_w_bit=captured_word[o_w_sel]=0.
  - o_w_ready=1 once reset deasserts.
- States: IDLE, SHIFT.
- IDLE:
  - o_w_ready=1, o_w_bit_valid=0.
  - On i_w_valid & o_w_ready at an edge: capture i_w_data, load sel with its start index, go to SHIFT.
- SHIFT:
  - o_w_bit_valid=1, o_w_busy=1.
  - o_w_bit = captured_word[o_w_sel], combinational through the mux instance.
  - o_w_last=1 when o_w_sel equals the end index: W-1 (LSB-first) or 0 (MSB-first).
  - Bit transfer = o_w_bit_valid & i_w_bit_ready at an edge.
  - On a transfer with o_w_last=0: sel advances by +1 (LSB-first) or -1 (MSB-first).
  - On a transfer with o_w_last=1: go to IDLE and reset sel to its start index, unless a new word is accepted in the same cycle (see below).
  - With i_w_bit_ready=0: sel, bit and last hold unchanged for any number of cycles.
- Back-to-back:
  - o_w_ready = IDLE | (SHIFT & o_w_last & i_w_bit_ready). This is combinational from i_w_bit_ready; there is no path from i_w_valid to o_w_ready.
  - If the last bit transfers and a new word is accepted on the same edge: capture the new word, reload sel with its start index, stay in SHIFT. There is no bubble cycle.
- Latency and throughput:
  - A word accepted at edge N presents its first bit in the cycle after edge N.
  - With i_w_bit_ready held at 1, a word takes exactly W cycles in SHIFT.
  - Back-to-back sustains 1 bit/cycle.
- i_w_data and i_w_valid are ignored whenever o_w_ready=0; the captured word never changes mid-serialization.
- Sel arithmetic is p_sel_width bits wide. The counter never wraps inside a word because the end index always terminates the word.
- Reset asserted mid-word:
  - The word is discarded and all outputs return to reset values immediately.
  - No further bits of that word appear after reset releases.
- p_sel_width=1 (W=2) must work: 2 bits per word.

Test Plan:
- Reset: assert i_w_reset mid-cycle with no clock edge -> o_w_bit_valid=0, o_w_busy=0, o_w_sel=0 immediately; after release o_w_ready=1.
- LSB-first, W=4, i_w_data=4'hA, i_w_bit_ready=1 -> over 4 cycles o_w_sel=0,1,2,3, o_w_bit=0,1,0,1, o_w_last=1 only on sel=3; then IDLE with o_w_ready=1.
- Backpressure, data 4'h6 -> hold i_w_bit_ready=0 for 3 cycles at sel=1: o_w_bit=1, sel=1 stable; on release the sequence continues with sel=2, bit=1, then sel=3, bit=0.
- Back-to-back: 4'h3 then 4'hC with i_w_valid held high -> 8 consecutive valid bits 1,1,0,0,0,0,1,1; o_w_ready=1 only in the last-bit cycle of the first word; no gap cycle.
- Mid-word reset: accept 4'hF, assert reset after 2 bits -> immediate idle outputs; after release no stale bits, and the next word 4'h1 serializes as 1,0,0,0.
- p_msb_first=1, p_sel_width=3, data 8'h81 -> o_w_sel=7..0, bits 1,0,0,0,0,0,0,1, o_w_last on sel=0; every cycle checks o_w_bit === i_w_data[o_w_sel].

Source files
------------

// File: rtl/mux_serializer.sv
// rtl/mux_serializer.sv - parallel-in serial-out stage driving one bit per transfer through a select mux

// Parameterized bit-select mux: y = data[sel]
module mux #(
  parameter int p_sel_width = 2
) (
  input  logic [2**p_sel_width-1:0] data,
  input  logic [p_sel_width-1:0]    sel,
  output logic                      y
);

  assign y = data[sel];

endmodule

module mux_serializer #(
  parameter int p_sel_width = 2,
  parameter int p_msb_first = 0
) (
  input  logic                      i_w_clk,
  input  logic                      i_w_reset,
  input  logic [2**p_sel_width-1:0] i_w_data,
  input  logic                      i_w_valid,
  output logic                      o_w_ready,
  output logic                      o_w_bit,
  output logic [p_sel_width-1:0]    o_w_sel,
  output logic                      o_w_bit_valid,
  input  logic                      i_w_bit_ready,
  output logic                      o_w_last,
  output logic                      o_w_busy
);

  localparam int c_w = 2**p_sel_width;

  // First and final bit index of a word, depending on shift direction
  localparam logic [p_sel_width-1:0] c_start = (p_msb_first != 0) ? {p_sel_width{1'b1}} : '0;
  localparam logic [p_sel_width-1:0] c_end   = (p_msb_first != 0) ? '0 : {p_sel_width{1'b1}};

  typedef enum logic {
    st_idle,
    st_shift
  } state_t;

  state_t                   state_q;
  logic [c_w-1:0]           word_q;
  logic [p_sel_width-1:0]   sel_q;
  logic [p_sel_width-1:0]   sel_step;
  logic                     last_q;
  logic                     valid_q;
  logic                     busy_q;
  logic                     accept;
  logic                     bit_xfer;

  // Next index in the shift direction; never wraps because c_end terminates the word
  assign sel_step = (p_msb_first != 0) ? (sel_q - 1'b1) : (sel_q + 1'b1);

  // Ready while idle, or in the last-bit cycle when the consumer takes that bit (no bubble)
  assign o_w_ready = !i_w_reset &&
                     ((state_q == st_idle) ||
                      ((state_q == st_shift) && last_q && i_w_bit_ready));

  assign accept   = i_w_valid && o_w_ready;
  assign bit_xfer = valid_q && i_w_bit_ready;

  // Serializer FSM: capture on accept, step sel on each bit transfer
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      state_q <= st_idle;
      word_q  <= '0;
      sel_q   <= c_start;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        st_idle: begin
          if (accept) begin
            word_q  <= i_w_data;
            sel_q   <= c_start;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= st_shift;
          end
        end
        st_shift: begin
          if (bit_xfer) begin
            if (!last_q) begin
              sel_q  <= sel_step;
              last_q <= (sel_step == c_end);
            end else if (accept) begin
              word_q <= i_w_data;
              sel_q  <= c_start;
              last_q <= 1'b0;
            end else begin
              sel_q   <= c_start;
              last_q  <= 1'b0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= st_idle;
            end
          end
        end
        default: begin
          state_q <= st_idle;
          sel_q   <= c_start;
          last_q  <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  mux #(.p_sel_width(p_sel_width)) u_mux (
    .data (word_q),
    .sel  (sel_q),
    .y    (o_w_bit)
  );

  assign o_w_sel       = sel_q;
  assign o_w_last      = last_q;
  assign o_w_bit_valid = valid_q;
  assign o_w_busy      = busy_q;

endmodule

// File: tb/tb_mux_serializer.sv
// tb/tb_mux_serializer.sv - directed self-checking bench for mux_serializer

module tb_mux_serializer;

  logic       clk;
  logic       rst;

  // LSB-first, W=4 instance
  logic [3:0] a_data;
  logic       a_valid;
  logic       a_ready;
  logic       a_bit;
  logic [1:0] a_sel;
  logic       a_bit_valid;
  logic       a_bit_ready;
  logic       a_last;
  logic       a_busy;

  // MSB-first, W=8 instance
  logic [7:0] b_data;
  logic       b_valid;
  logic       b_ready;
  logic       b_bit;
  logic [2:0] b_sel;
  logic       b_bit_valid;
  logic       b_bit_ready;
  logic       b_last;
  logic       b_busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_a;
  logic [7:0] exp_b8;
  logic [7:0] exp_seq;

  mux_serializer #(.p_sel_width(2), .p_msb_first(0)) dut_a (
    .i_w_clk       (clk),
    .i_w_reset     (rst),
    .i_w_data      (a_data),
    .i_w_valid     (a_valid),
    .o_w_ready     (a_ready),
    .o_w_bit       (a_bit),
    .o_w_sel       (a_sel),
    .o_w_bit_valid (a_bit_valid),
    .i_w_bit_ready (a_bit_ready),
    .o_w_last      (a_last),
    .o_w_busy      (a_busy)
  );

  mux_serializer #(.p_sel_width(3), .p_msb_first(1)) dut_b (
    .i_w_clk       (clk),
    .i_w_reset     (rst),
    .i_w_data      (b_data),
    .i_w_valid     (b_valid),
    .o_w_ready     (b_ready),
    .o_w_bit       (b_bit),
    .o_w_sel       (b_sel),
    .o_w_bit_valid (b_bit_valid),
    .i_w_bit_ready (b_bit_ready),
    .o_w_last      (b_last),
    .o_w_busy      (b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_valid = 1'b0; a_bit_ready = 1'b0;
    b_data = '0; b_valid = 1'b0; b_bit_ready = 1'b0;
    #2;
    check("rst_a_bit_valid", 32'(a_bit_valid), 0);
    check("rst_a_busy", 32'(a_busy), 0);
    check("rst_a_sel", 32'(a_sel), 0);
    check("rst_a_bit", 32'(a_bit), 0);
    check("rst_b_sel", 32'(b_sel), 7);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_a_ready", 32'(a_ready), 1);
    check("post_rst_b_ready", 32'(b_ready), 1);

    // LSB-first 4'hA with consumer always ready
    exp_a = 4'b1010;
    a_data = 4'hA; a_valid = 1'b1; a_bit_ready = 1'b1;
    #1;
    check("lsb_idle_bit_valid", 32'(a_bit_valid), 0);
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("lsb_sel", 32'(a_sel), 32'(i));
      check("lsb_bit", 32'(a_bit), 32'(exp_a[i]));
      check("lsb_last", 32'(a_last), (i == 3) ? 1 : 0);
      check("lsb_busy", 32'(a_busy), 1);
      check("lsb_ready", 32'(a_ready), (i == 3) ? 1 : 0);
      tick();
    end
    #1;
    check("lsb_end_bit_valid", 32'(a_bit_valid), 0);
    check("lsb_end_ready", 32'(a_ready), 1);
    check("lsb_end_sel", 32'(a_sel), 0);

    // Backpressure on 4'h6 at sel=1
    a_data = 4'h6; a_valid = 1'b1;
    tick();
    a_valid = 1'b0; a_data = 4'h9;
    #1;
    check("bp_sel0", 32'(a_sel), 0);
    check("bp_bit0", 32'(a_bit), 0);
    tick();
    a_bit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_sel", 32'(a_sel), 1);
      check("bp_hold_bit", 32'(a_bit), 1);
      check("bp_hold_last", 32'(a_last), 0);
      tick();
    end
    a_bit_ready = 1'b1;
    #1;
    check("bp_release_sel", 32'(a_sel), 1);
    tick();
    #1;
    check("bp_sel2", 32'(a_sel), 2);
    check("bp_bit2", 32'(a_bit), 1);
    tick();
    #1;
    check("bp_sel3", 32'(a_sel), 3);
    check("bp_bit3", 32'(a_bit), 0);
    check("bp_last3", 32'(a_last), 1);
    tick();
    #1;
    check("bp_end_bit_valid", 32'(a_bit_valid), 0);

    // Back-to-back 4'h3 then 4'hC, valid held high
    exp_seq = 8'b1100_0011;
    a_data = 4'h3; a_valid = 1'b1;
    tick();
    a_data = 4'hC;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) a_valid = 1'b0;
      #1;
      check("b2b_bit_valid", 32'(a_bit_valid), 1);
      check("b2b_bit", 32'(a_bit), 32'(exp_seq[i]));
      check("b2b_sel", 32'(a_sel), 32'(i % 4));
      check("b2b_ready", 32'(a_ready), (i == 3 || i == 7) ? 1 : 0);
      tick();
    end
    #1;
    check("b2b_end_bit_valid", 32'(a_bit_valid), 0);

    // Mid-word reset on 4'hF after two bits
    a_data = 4'hF; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    #1;
    check("mrst_pre_sel", 32'(a_sel), 2);
    #1;
    rst = 1'b1;
    #1;
    check("mrst_bit_valid", 32'(a_bit_valid), 0);
    check("mrst_busy", 32'(a_busy), 0);
    check("mrst_sel", 32'(a_sel), 0);
    check("mrst_bit", 32'(a_bit), 0);
    check("mrst_last", 32'(a_last), 0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst_rel_ready", 32'(a_ready), 1);
    check("mrst_rel_bit_valid", 32'(a_bit_valid), 0);
    tick();
    check("mrst_no_stale", 32'(a_bit_valid), 0);
    exp_a = 4'b0001;
    a_data = 4'h1; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mrst_next_bit", 32'(a_bit), 32'(exp_a[i]));
      check("mrst_next_sel", 32'(a_sel), 32'(i));
      tick();
    end
    #1;
    check("mrst_next_end", 32'(a_bit_valid), 0);

    // MSB-first W=8, data 8'h81
    exp_b8 = 8'b1000_0001;
    b_data = 8'h81; b_valid = 1'b1; b_bit_ready = 1'b1;
    tick();
    b_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("msb_sel", 32'(b_sel), 32'(7 - i));
      check("msb_bit", 32'(b_bit), 32'(exp_b8[7 - i]));
      check("msb_bit_vs_data", 32'(b_bit), 32'(b_data[b_sel]));
      check("msb_last", 32'(b_last), (i == 7) ? 1 : 0);
      tick();
    end
    #1;
    check("msb_end_bit_valid", 32'(b_bit_valid), 0);
    check("msb_end_sel", 32'(b_sel), 7);
    check("msb_end_ready", 32'(b_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
